// File: rtl/scan_controller_pkg.sv
// Shared sizes and all-off drive constants for the LED matrix / 7-seg scan controller.
package scan_pkg;
  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;
  localparam int N_DIGS = 3;
  localparam int N_SEGS = 7;
  localparam int COL_AW = 3;
  localparam int DIG_AW = 2;

  // Pin levels that leave every LED dark (digit enables and segments are active-low).
  localparam logic [N_COLS-1:0] COLS_OFF = '0;
  localparam logic [N_ROWS-1:0] ROWS_OFF = '0;
  localparam logic [N_DIGS-1:0] DIGS_OFF = '1;
  localparam logic [N_SEGS-1:0] SEGS_OFF = '1;
endpackage

// File: rtl/scan_controller_if.sv
// Buffer write bus from the decoder plus the physical display pins.
interface scan_controller_if;
  import scan_pkg::*;

  logic              col_wr;
  logic [COL_AW-1:0] col_addr;
  logic [N_ROWS-1:0] col_data;
  logic              dig_wr;
  logic [DIG_AW-1:0] dig_addr;
  logic [N_SEGS-1:0] dig_data;

  logic [N_COLS-1:0] cols;
  logic [N_ROWS-1:0] rows;
  logic [N_DIGS-1:0] digs;
  logic [N_SEGS-1:0] segs;
  logic              slot_tick;

  modport master (
    output col_wr, col_addr, col_data, dig_wr, dig_addr, dig_data,
    input  cols, rows, digs, segs, slot_tick
  );

  modport slave (
    input  col_wr, col_addr, col_data, dig_wr, dig_addr, dig_data,
    output cols, rows, digs, segs, slot_tick
  );
endinterface

// File: rtl/scan_controller_divider.sv
// Slot prescaler: counts clocks within a slot, freezes while disabled, flags the blank gap.
module scan_divider #(
    parameter int CLK_DIV = 50000,
    parameter int BLANK   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic blank
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] div_cnt;

    // tick is qualified by en so a frozen last cycle never advances the slot
    assign tick  = en && (div_cnt == CW'(CLK_DIV - 1));
    assign blank = (div_cnt < CW'(BLANK));

    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else if (en)
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
endmodule

// File: rtl/scan_controller.sv
// Column/digit time-multiplexer: frame and digit buffers, slot indices, registered pin drive.
module scan_controller import scan_pkg::*; #(
    parameter int CLK_DIV = 50000,
    parameter int BLANK   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    scan_controller_if.slave  bus
);
    logic [N_ROWS-1:0] fb [N_COLS];
    logic [N_SEGS-1:0] db [N_DIGS];
    logic [2:0]        col_idx;
    logic [1:0]        dig_idx;
    logic              tick;
    logic              blank;

    scan_divider #(.CLK_DIV(CLK_DIV), .BLANK(BLANK)) u_div (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .tick  (tick),
        .blank (blank)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx <= '0;
            dig_idx <= '0;
        end else if (tick) begin
            col_idx <= (col_idx == 3'(N_COLS - 1)) ? '0 : col_idx + 1'b1;
            dig_idx <= (dig_idx == 2'(N_DIGS - 1)) ? '0 : dig_idx + 1'b1;
        end
    end

    // Out-of-range addresses simply fall through without touching any entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_COLS; i++) fb[i] <= '0;
            for (int i = 0; i < N_DIGS; i++) db[i] <= '0;
        end else begin
            if (bus.col_wr && (bus.col_addr < COL_AW'(N_COLS)))
                fb[bus.col_addr] <= bus.col_data;
            if (bus.dig_wr && (bus.dig_addr < DIG_AW'(N_DIGS)))
                db[bus.dig_addr] <= bus.dig_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en || blank) begin
            bus.cols <= COLS_OFF;
            bus.rows <= ROWS_OFF;
            bus.digs <= DIGS_OFF;
            bus.segs <= SEGS_OFF;
        end else begin
            bus.cols <= N_COLS'(1) << col_idx;
            bus.rows <= fb[col_idx];
            bus.digs <= ~(N_DIGS'(1) << dig_idx);
            bus.segs <= ~db[dig_idx];
        end
        bus.slot_tick <= !rst && tick;
    end
endmodule
